// File: rtl/uart_baud_gen.sv
// Programmable UART baud-tick generator: runtime divisor with range check,
// mid-bit sample strobe, start-edge resync and frame-position tracking.
module uart_baud_gen #(
  parameter int CNT_W       = 14,
  parameter int DIV_DEFAULT = 10417,
  parameter int DIV_MIN     = 4,
  parameter int FRAME_BITS  = 10,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             div_ld_i,
  input  logic [CNT_W-1:0] div_i,
  output logic [CNT_W-1:0] div_o,
  output logic             div_err_o,
  output logic             bit_tick_o,
  output logic             mid_tick_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic             frame_done_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_ld_ok;
  logic             w_qual;
  logic             w_end;
  logic             w_bit;
  logic             w_mid;
  logic             w_wrap;

  assign w_ld_ok = div_ld_i && (div_i >= CNT_W'(DIV_MIN));
  // Any restart condition (disable, resync, new divisor) also kills ticks.
  assign w_qual  = en_i && !sync_i && !w_ld_ok;
  assign w_end   = (r_cnt >= div_o - CNT_W'(1));
  assign w_bit   = w_qual && (r_cnt == div_o - CNT_W'(1));
  assign w_mid   = w_qual && (r_cnt == (div_o >> 1) - CNT_W'(1));
  assign w_wrap  = (bit_idx_o == IDX_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_o     <= CNT_W'(DIV_DEFAULT);
      div_err_o <= 1'b0;
    end else if (div_ld_i) begin
      if (w_ld_ok) begin
        div_o     <= div_i;
        div_err_o <= 1'b0;
      end else begin
        div_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!w_qual || w_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_tick_o   <= 1'b0;
      mid_tick_o   <= 1'b0;
      frame_done_o <= 1'b0;
      bit_idx_o    <= '0;
    end else begin
      bit_tick_o   <= w_bit;
      mid_tick_o   <= w_mid;
      frame_done_o <= w_bit && w_wrap;
      if (!w_qual) begin
        bit_idx_o <= '0;
      end else if (w_bit) begin
        bit_idx_o <= w_wrap ? '0 : bit_idx_o + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: a modular-arithmetic reference model
// predicts each cycle's outputs; a monitor compares them after every edge.
module tb_uart_baud_gen;
  localparam int CNT_W = 14;
  localparam int DDEF  = 10417;
  localparam int DMIN  = 4;
  localparam int FB    = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en_i = 1'b0;
  logic             sync_i = 1'b0;
  logic             div_ld_i = 1'b0;
  logic [CNT_W-1:0] div_i = '0;
  logic [CNT_W-1:0] div_o;
  logic             div_err_o, bit_tick_o, mid_tick_o, frame_done_o;
  logic [IDX_W-1:0] bit_idx_o;

  uart_baud_gen dut (
    .clk(clk), .rstn(rstn), .en_i(en_i), .sync_i(sync_i),
    .div_ld_i(div_ld_i), .div_i(div_i), .div_o(div_o),
    .div_err_o(div_err_o), .bit_tick_o(bit_tick_o), .mid_tick_o(mid_tick_o),
    .bit_idx_o(bit_idx_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic             err;
    logic             btk;
    logic             mtk;
    logic [IDX_W-1:0] idx;
    logic             done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   armed = 0;

  // Reference state: edges are numbered; a period starts at edge s, so the
  // phase at qualified edge n is (n - s) mod D.
  int m_div = DDEF;
  bit m_err = 0;
  int m_n   = 0;
  int m_s   = 0;

  task automatic step(input bit rst, input bit en, input bit sy,
                      input bit ld, input int dv);
    exp_t e;
    bit   acc, qual;
    int   ph, nt;
    @(negedge clk);
    rstn = ~rst; en_i = en; sync_i = sy; div_ld_i = ld; div_i = CNT_W'(dv);
    acc  = !rst && ld && (dv >= DMIN);
    qual = !rst && en && !sy && !acc;
    e = '0;
    if (qual) begin
      ph    = m_n - m_s;
      nt    = (ph + 1) / m_div;
      e.btk = (ph % m_div) == m_div - 1;
      e.mtk = (ph % m_div) == (m_div / 2) - 1;
      e.idx = IDX_W'(nt % FB);
      e.done = e.btk && (nt % FB == 0);
    end else begin
      m_s = m_n + 1;
    end
    if (rst) begin
      m_div = DDEF; m_err = 0;
    end else if (ld) begin
      if (acc) begin m_div = dv; m_err = 0; end
      else m_err = 1;
    end
    e.div = CNT_W'(m_div);
    e.err = m_err;
    m_n++;
    q.push_back(e);
    armed = 1;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, en, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{div_o, div_err_o, bit_tick_o, mid_tick_o, bit_idx_o, frame_done_o};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle%0d outputs: got div=%0d err=%b bit=%b mid=%b idx=%0d done=%b, want div=%0d err=%b bit=%b mid=%b idx=%0d done=%b",
                 tests, a.div, a.err, a.btk, a.mtk, a.idx, a.done,
                 e.div, e.err, e.btk, e.mtk, e.idx, e.done);
      end
    end else if (armed) begin
      tests++; fails++;
      $display("FAIL scoreboard: got empty queue, want an expected entry");
    end
  end

  initial begin
    // reset held with enable high
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    // D=10 from idle, run past one full frame
    step(0, 0, 0, 1, 10);
    run(115, 1);
    // resync mid-period
    step(0, 0, 0, 0, 0);
    run(7, 1);
    step(0, 1, 1, 0, 0);
    run(25, 1);
    // rejected then minimum divisor
    step(0, 1, 0, 1, 3);
    run(6, 1);
    step(0, 1, 0, 1, 4);
    run(45, 1);
    // enable drop mid-period
    step(0, 0, 0, 1, 10);
    run(13, 1);
    run(5, 0);
    run(25, 1);
    // load colliding with a pending bit tick
    step(0, 0, 0, 1, 10);
    run(9, 1);
    step(0, 1, 0, 1, 20);
    run(45, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, en, sy, ld;
      int dv;
      r  = ($urandom_range(0, 399) == 0);
      en = ($urandom_range(0, 19) != 0);
      sy = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 39) == 0);
      dv = $urandom_range(0, 24);
      step(r, en, sy, ld, dv);
    end
    step(0, 1, 0, 1, 4);
    run(50, 1);
    @(negedge clk);
    armed = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Programmable UART baud-tick generator for the readout network. It is the successor to the fixed-divisor bit-clock block and differs from it in four ways: the divisor can be loaded at runtime and is range-checked, it emits a mid-bit sample strobe for the receiver, a sync input restarts the bit phase on a start-bit edge, and a frame-position counter reports frame completion. UART TX and RX state machines use its one-cycle tick pulses as clock enables in the `clk` domain.

## Interface
Parameters:
- `CNT_W`, 14: width of divisor and phase counter.
- `DIV_DEFAULT`, 10417: divisor after reset, in clk cycles per bit.
- `DIV_MIN`, 4: smallest divisor accepted by a load.
- `FRAME_BITS`, 10: bit periods per frame (start + 8 data + stop).
- `IDX_W`, 4: width of `bit_idx_o`; must satisfy 2^IDX_W >= FRAME_BITS.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rstn`, in, 1: synchronous, active-low reset.
- `en_i`, in, 1: run enable; low holds the generator cleared.
- `sync_i`, in, 1: one-cycle pulse that restarts the bit phase and frame position.
- `div_ld_i`, in, 1: one-cycle strobe that loads `div_i`.
- `div_i`, in, CNT_W: requested divisor.
- `div_o`, out, CNT_W: active divisor.
- `div_err_o`, out, 1: sticky flag, set when a load is rejected.
- `bit_tick_o`, out, 1: one-cycle pulse at the end of each bit period.
- `mid_tick_o`, out, 1: one-cycle pulse at the middle of each bit period.
- `bit_idx_o`, out, IDX_W: index of the current bit within the frame.
- `frame_done_o`, out, 1: one-cycle pulse on the bit tick that completes a frame.

## Operation
- All outputs are registered. Reset values: `div_o`=DIV_DEFAULT; `div_err_o`, `bit_tick_o`, `mid_tick_o`, `frame_done_o` = 0; `bit_idx_o`=0. The internal phase counter `cnt` resets to 0.
- Divisor load is independent of `en_i` and `sync_i`:
  - `div_ld_i` with `div_i` >= DIV_MIN: `div_o`<=`div_i` and `div_err_o`<=0. The load is accepted.
  - `div_ld_i` with `div_i` < DIV_MIN: `div_o` is unchanged and `div_err_o`<=1.
- Phase counter priority, highest first:
  1. `rstn`=0
  2. `en_i`=0
  3. `sync_i`=1
  4. accepted load
  5. `cnt` >= `div_o`-1
  6. otherwise `cnt`<=`cnt`+1

  Cases 1-5 set `cnt`<=0. The >= compare guards against `cnt` running past the divisor.
- Tick qualification: a tick is "qualified" only on an edge where `en_i`=1, `sync_i`=0 and no load is accepted. Every tick output is 0 on unqualified edges.
  - `bit_tick_o`<=1 on a qualified edge where `cnt`==`div_o`-1.
  - `mid_tick_o`<=1 on a qualified edge where `cnt`==(`div_o`>>1)-1, using floor division.
- Frame position:
  - `bit_idx_o` clears under case 1-4 conditions.
  - On each qualified bit tick, `bit_idx_o` increments, and wraps to 0 at FRAME_BITS-1.
  - `frame_done_o`<=1 on the edge where `bit_idx_o` wraps from FRAME_BITS-1 to 0.
- Reset mid-period takes effect at the next edge. `div_o` returns to DIV_DEFAULT and any period in progress is discarded.

## Timing
- Let E0 be the edge where `en_i` is first sampled high with `cnt`=0. Measured from E0:
  - `mid_tick_o` first rises after edge floor(D/2).
  - `bit_tick_o` first rises after edge D.
  - Both ticks then repeat every D cycles, where D=`div_o`.
- Each tick is high for exactly one cycle. For D >= DIV_MIN the two ticks never coincide.
- `sync_i` or an accepted load at edge S restarts the period: `mid_tick_o` after edge S+floor(D/2) and `bit_tick_o` after edge S+D, with the new D.
- `div_o` and `div_err_o` update one cycle after the `div_ld_i` edge.
- `frame_done_o` is high in the same cycle as the FRAME_BITS-th `bit_tick_o` after a restart, and `bit_idx_o` reads 0 in that cycle.
- Dropping `en_i` takes effect on the next edge, with no residual tick. Re-enabling starts a full period of D cycles.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles with `en_i`=1 → `div_o`=10417, every tick output 0, `bit_idx_o`=0, `div_err_o`=0.
- Load `div_i`=10, then `en_i`=1 from E0 → `mid_tick_o` at E0+5, 15, 25…; `bit_tick_o` at E0+10, 20…; `frame_done_o` with the tick at E0+100; `bit_idx_o` counts 1…9 then 0.
- With D=10, pulse `sync_i` at E0+7 → no tick at E0+10; `mid_tick_o` at E0+12, `bit_tick_o` at E0+17; `bit_idx_o` cleared to 0.
- Load `div_i`=3 → `div_o` unchanged, `div_err_o`=1. Then load `div_i`=4 → `div_err_o`=0, `mid_tick_o` every 4 cycles at offset 2, `bit_tick_o` at offset 4, never overlapping.
- With D=10, drop `en_i` at E0+13 for 5 cycles, then re-enable at edge R → no ticks while disabled, `bit_idx_o`=0, first `bit_tick_o` at R+10.
- Assert `div_ld_i` (`div_i`=20) in the same cycle as a pending `bit_tick` (`cnt`=9, D=10) → that tick is suppressed, `div_o`=20 next cycle, next `bit_tick_o` 20 cycles after the load edge.
